// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding selects and load-use hazard control for a 5-stage pipeline.
// Selects are computed from the EX/MEM shadows before they shift, so they are ready when the instruction enters EX.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ext_stall,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
  } ex_sh_t;

  // Past EX only the write target matters; the WB data path is selected
  // while its producer is still in MEM, so no WB shadow is kept.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
  } mem_sh_t;

  typedef enum logic {RUN, STALL} state_t;

  ex_sh_t  ex;
  mem_sh_t mem;
  state_t  state;

  function automatic logic writes(input logic v, input logic rw,
                                  input logic [REG_AW-1:0] d,
                                  input logic [REG_AW-1:0] r);
    return v && rw && (d == r) && (r != '0);
  endfunction

  function automatic logic [1:0] pick(input logic use_r, input logic ex_w,
                                      input logic mem_w);
    if (!use_r)     return 2'b00;
    else if (ex_w)  return 2'b01;
    else if (mem_w) return 2'b10;
    else            return 2'b00;
  endfunction

  logic ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt, hazard;
  logic [1:0] sel_a, sel_b;

  always_comb begin
    ex_wr_rs  = writes(ex.valid, ex.regwrite, ex.dst, id_rs);
    ex_wr_rt  = writes(ex.valid, ex.regwrite, ex.dst, id_rt);
    mem_wr_rs = writes(mem.valid, mem.regwrite, mem.dst, id_rs);
    mem_wr_rt = writes(mem.valid, mem.regwrite, mem.dst, id_rt);
    hazard    = ex.valid && ex.memread && id_valid && !flush &&
                ((id_use_rs && ex_wr_rs) || (id_use_rt && ex_wr_rt));
    stall     = hazard && !ext_stall;
    bubble    = (hazard || flush) && !ext_stall;
    sel_a     = pick(id_use_rs, ex_wr_rs, mem_wr_rs);
    sel_b     = pick(id_use_rt, ex_wr_rt, mem_wr_rt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex        <= '0;
      mem       <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
      state     <= RUN;
    end else if (!ext_stall) begin
      mem <= '{valid: ex.valid, dst: ex.dst, regwrite: ex.regwrite};
      if (bubble) begin
        ex        <= '0;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end else begin
        ex        <= '{valid: id_valid, dst: id_dst, regwrite: id_regwrite,
                       memread: id_memread};
        fwd_a_sel <= sel_a;
        fwd_b_sel <= sel_b;
      end
      // The re-checked consumer sees the load in MEM, so STALL always returns to RUN.
      case (state)
        RUN:     state <= stall ? STALL : RUN;
        default: state <= RUN;
      endcase
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
